// File: rtl/adder_ctrl_pkg.sv
// Shared types and helpers for the adder_arbiter block: FSM state encoding,
// the default watchdog limit and the requester-id width derivation.
package adder_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // Maximum number of WAIT cycles before an operation is aborted.
   localparam int DEFAULT_TIMEOUT = 15;

   // Bits needed to encode a requester index; never less than 1.
   function automatic int id_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Bundle of the requester, response and adder-side signals of adder_arbiter.
// slave: the arbiter's view; master: the surrounding environment's view.
interface adder_arbiter_if
   import adder_ctrl_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   parameter int IDW   = id_width(NREQ)
);

   // Requester side
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_cin;

   // Response channel
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_cout;
   logic                  rsp_err;

   // Shared dynamic adder
   logic                  adder_f;
   logic [WIDTH-1:0]      adder_a;
   logic [WIDTH-1:0]      adder_b;
   logic                  adder_cin;
   logic                  adder_r;
   logic [WIDTH-1:0]      adder_sum;
   logic                  adder_cout;

   modport slave (
      input  req_valid, req_a, req_b, req_cin, rsp_ready,
             adder_r, adder_sum, adder_cout,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_err,
             adder_f, adder_a, adder_b, adder_cin
   );

   modport master (
      output req_valid, req_a, req_b, req_cin, rsp_ready,
             adder_r, adder_sum, adder_cout,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_err,
             adder_f, adder_a, adder_b, adder_cin
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr
// (wrapping NREQ-1 -> 0). Grant is one-hot or zero; zero when en is low.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  id
);

   logic found;
   int   idx;

   // Search from ptr+1 with wrap-around and pick the first active request.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
      grant = '0;
      id    = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = (int'(ptr) + i) % NREQ;
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            id         = IDW'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one dynamic adder (start F, done R) among NREQ
// requesters. Round-robin grant, one-cycle F pulse, wait for R with a
// watchdog, then return sum/cout tagged with the requester id.
// Optional statistics outputs are enabled by defining ADDER_ARB_STATS_EN.
module adder_arbiter
   import adder_ctrl_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int IDW     = id_width(NREQ)
) (
   input  logic           clk,
   input  logic           reset_n,
   adder_arbiter_if.slave bus,
   output logic           busy
`ifdef ADDER_ARB_STATS_EN
   ,
   output logic [31:0]    stat_ops,
   output logic [15:0]    stat_timeouts,
   output logic [7:0]     stat_wait_max
`endif
);

   state_t          state;
   state_t          state_nxt;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  grant_id;
   logic [NREQ-1:0] grant;
   logic            arb_en;
   logic            accept;
   logic            wait_done;
   logic            rsp_hs;
   logic [7:0]      wait_cnt;

   // Grants are only offered while idle and out of reset.
   assign arb_en = (state == ST_IDLE) && reset_n;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .en    (arb_en),
      .grant (grant),
      .id    (grant_id)
   );

   assign bus.req_ready = grant;
   assign accept        = |grant;
   // R wins over the watchdog when both occur in the same cycle.
   assign wait_done     = (state == ST_WAIT) &&
                          (bus.adder_r || (wait_cnt == 8'(TIMEOUT - 1)));
   assign rsp_hs        = (state == ST_RESP) && bus.rsp_ready;
   assign busy          = (state != ST_IDLE);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept)    state_nxt = ST_LAUNCH;
         ST_LAUNCH:                state_nxt = ST_WAIT;
         ST_WAIT:   if (wait_done) state_nxt = ST_RESP;
         ST_RESP:   if (rsp_hs)    state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture, F pulse and round-robin pointer update on accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.adder_f   <= 1'b0;
         bus.adder_a   <= '0;
         bus.adder_b   <= '0;
         bus.adder_cin <= 1'b0;
         ptr           <= IDW'(NREQ - 1);
      end else begin
         bus.adder_f <= accept;
         if (accept) begin
            bus.adder_a   <= bus.req_a[grant_id*WIDTH +: WIDTH];
            bus.adder_b   <= bus.req_b[grant_id*WIDTH +: WIDTH];
            bus.adder_cin <= bus.req_cin[grant_id];
            ptr           <= grant_id;
         end
      end
   end

   // Watchdog: cleared in LAUNCH, counts WAIT cycles without R.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if (state == ST_LAUNCH) begin
         wait_cnt <= '0;
      end else if ((state == ST_WAIT) && !bus.adder_r) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Response registers: capture on R or abort, hold until handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_sum   <= '0;
         bus.rsp_cout  <= 1'b0;
         bus.rsp_err   <= 1'b0;
      end else if (wait_done) begin
         bus.rsp_valid <= 1'b1;
         bus.rsp_id    <= ptr;
         if (bus.adder_r) begin
            bus.rsp_sum  <= bus.adder_sum;
            bus.rsp_cout <= bus.adder_cout;
            bus.rsp_err  <= 1'b0;
         end else begin
            bus.rsp_sum  <= '0;
            bus.rsp_cout <= 1'b0;
            bus.rsp_err  <= 1'b1;
         end
      end else if (rsp_hs) begin
         bus.rsp_valid <= 1'b0;
      end
   end

`ifdef ADDER_ARB_STATS_EN
   logic [7:0] op_wait;

   // Saturating statistics, updated on each response handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_wait       <= '0;
         stat_ops      <= '0;
         stat_timeouts <= '0;
         stat_wait_max <= '0;
      end else begin
         if (wait_done) op_wait <= wait_cnt + 8'd1;
         if (rsp_hs) begin
            if (stat_ops != '1) stat_ops <= stat_ops + 32'd1;
            if (bus.rsp_err && (stat_timeouts != '1))
               stat_timeouts <= stat_timeouts + 16'd1;
            if (op_wait > stat_wait_max) stat_wait_max <= op_wait;
         end
      end
   end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a table of single operations with
// hand-computed results, plus sequences for stale R, backpressure,
// round-robin rotation and reset during WAIT. Includes a behavioural
// dynamic-adder model with programmable R delay (0 = never).
module tb_adder_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 15;
   localparam int IDW     = 2;

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      int          delay;
      logic [31:0] sum;
      logic        cout;
      logic        err;
   } vec_t;

   logic clk;
   logic reset_n;
   logic busy;
`ifdef ADDER_ARB_STATS_EN
   logic [31:0] stat_ops;
   logic [15:0] stat_timeouts;
   logic [7:0]  stat_wait_max;
`endif

   adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   adder_arbiter #(
      .NREQ    (NREQ),
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT),
      .IDW     (IDW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .busy          (busy)
`ifdef ADDER_ARB_STATS_EN
      ,
      .stat_ops      (stat_ops),
      .stat_timeouts (stat_timeouts),
      .stat_wait_max (stat_wait_max)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counters and bookkeeping
   int n_vec   = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int f_cnt   = 0;
   int hot_err = 0;
   int t_acc   = 0;
   int f_base  = 0;
   int last_id = 0;
   int n_rsp   = 0;

   // Adder model
   int          model_delay = 1;
   int          left        = 0;
   logic        model_r     = 1'b0;
   logic        stale_r     = 1'b0;
   logic [31:0] model_sum   = 32'h0;
   logic        model_cout  = 1'b0;
   logic [32:0] model_res;

   assign model_res      = {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {32'b0, bus.adder_cin};
   assign bus.adder_r    = model_r | stale_r;
   assign bus.adder_sum  = model_sum;
   assign bus.adder_cout = model_cout;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.adder_f) begin
         if (model_delay == 1) begin
            model_r                 <= 1'b1;
            {model_cout, model_sum} <= model_res;
            left                    <= 0;
         end else begin
            model_r <= 1'b0;
            left    <= (model_delay == 0) ? 0 : model_delay - 1;
         end
      end else if (left != 0) begin
         left <= left - 1;
         if (left == 1) begin
            model_r                 <= 1'b1;
            {model_cout, model_sum} <= model_res;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.adder_f) f_cnt <= f_cnt + 1;
      if ($countones(bus.req_ready) > 1) hot_err <= hot_err + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present one request and wait (bounded) for its grant and accept.
   task automatic request(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input int delay);
      int n;
      model_delay                = delay;
      bus.req_a[id*WIDTH +: WIDTH] = a;
      bus.req_b[id*WIDTH +: WIDTH] = b;
      bus.req_cin[id]            = cin;
      bus.req_valid[id]          = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.req_ready == '0 && n < 50);
      check("grant", 64'(bus.req_ready), 64'(4'b0001 << id));
      @(posedge clk);
      #1;
      t_acc             = cyc;
      f_base            = f_cnt;
      bus.req_valid[id] = 1'b0;
      last_id           = id;
   endtask

   // Wait (bounded) for the response and check it; handshake if rsp_ready.
   task automatic collect(input int id, input logic [31:0] sum, input logic cout,
                          input logic err, input int lat);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.rsp_valid !== 1'b1 && n < 100);
      check("rsp_valid", 64'(bus.rsp_valid), 64'(1));
      check("rsp_id",    64'(bus.rsp_id),    64'(id));
      check("rsp_sum",   64'(bus.rsp_sum),   64'(sum));
      check("rsp_cout",  64'(bus.rsp_cout),  64'(cout));
      check("rsp_err",   64'(bus.rsp_err),   64'(err));
      check("latency",   64'(cyc - t_acc),   64'(lat));
      check("f_pulses",  64'(f_cnt - f_base), 64'(1));
      if (bus.rsp_ready) begin
         @(posedge clk);
         #1;
         n_rsp++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t vecs[7];
      int   n;
      int   bp_bad;
      int   exp_id;
      int   base;

      vecs[0] = '{0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0,  3, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1] = '{2, 32'h1234_5678, 32'h1111_1111, 1'b1,  1, 32'h2345_678A, 1'b0, 1'b0};
      vecs[2] = '{1, 32'h8000_0000, 32'h8000_0000, 1'b0,  2, 32'h0000_0000, 1'b1, 1'b0};
      vecs[3] = '{3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1,  5, 32'h0000_0000, 1'b1, 1'b0};
      vecs[4] = '{0, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0,  0, 32'h0000_0000, 1'b0, 1'b1};
      vecs[5] = '{1, 32'h0000_FFFF, 32'h0000_0001, 1'b0,  1, 32'h0001_0000, 1'b0, 1'b0};
      vecs[6] = '{3, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 15, 32'h8000_0000, 1'b0, 1'b0};

      // Reset state, with every requester asking.
      reset_n       = 1'b0;
      bus.req_valid = '1;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_cin   = '0;
      bus.rsp_ready = 1'b1;
      #2;
      check("rst_busy",      64'(busy),          64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("rst_adder_f",   64'(bus.adder_f),   64'(0));
      check("rst_req_ready", 64'(bus.req_ready), 64'(0));
      check("rst_adder_a",   64'(bus.adder_a),   64'(0));
      check("rst_rsp_sum",   64'(bus.rsp_sum),   64'(0));
      repeat (3) @(posedge clk);
      #1;
      bus.req_valid = '0;
      reset_n       = 1'b1;
      @(posedge clk);
      #1;

      // Table of single operations, including timeout and R-at-deadline.
      for (int i = 0; i < 7; i++) begin
         request(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].delay);
         collect(vecs[i].id, vecs[i].sum, vecs[i].cout, vecs[i].err,
                 (vecs[i].delay == 0) ? TIMEOUT + 1 : vecs[i].delay + 1);
      end

      // Stale R held high through IDLE and LAUNCH must be ignored.
      stale_r = 1'b1;
      @(posedge clk);
      #1;
      request(2, 32'h0F0F_0F0F, 32'h1010_1010, 1'b0, 3);
      @(posedge clk);
      #1;
      stale_r = 1'b0;
      collect(2, 32'h1F1F_1F1F, 1'b0, 1'b0, 4);

      // Backpressure with requester 1 pending.
      bus.rsp_ready = 1'b0;
      request(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1);
      collect(0, 32'h0000_0100, 1'b0, 1'b0, 2);
      bus.req_a[1*WIDTH +: WIDTH] = 32'h3;
      bus.req_b[1*WIDTH +: WIDTH] = 32'h4;
      bus.req_cin[1]              = 1'b1;
      bus.req_valid[1]            = 1'b1;
      bp_bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'h100 ||
             bus.rsp_id !== 2'd0 || bus.req_ready !== 4'b0000) bp_bad++;
      end
      check("bp_stable", 64'(bp_bad), 64'(0));
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      model_delay   = 1;
      @(negedge clk);
      check("bp_hs_ready", 64'(bus.req_ready), 64'(0));
      n_rsp++;
      @(negedge clk);
      check("bp_next_grant", 64'(bus.req_ready), 64'(4'b0010));
      check("bp_rsp_clear",  64'(bus.rsp_valid), 64'(0));
      @(posedge clk);
      #1;
      t_acc            = cyc;
      f_base           = f_cnt;
      bus.req_valid[1] = 1'b0;
      last_id          = 1;
      collect(1, 32'h0000_0008, 1'b0, 1'b0, 2);

      // Round-robin with all requesters valid continuously.
      model_delay = 1;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*WIDTH +: WIDTH] = 32'(i + 1);
         bus.req_b[i*WIDTH +: WIDTH] = 32'(i * 256);
         bus.req_cin[i]              = 1'b0;
      end
      bus.req_valid = '1;
      base = last_id;
      for (int k = 0; k < 8; k++) begin
         exp_id = (base + 1 + k) % NREQ;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (bus.req_ready == '0 && n < 50);
         check("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << exp_id));
         @(posedge clk);
         #1;
         t_acc  = cyc;
         f_base = f_cnt;
         if (k == 7) bus.req_valid = '0;
         last_id = exp_id;
         collect(exp_id, 32'(exp_id + 1 + exp_id * 256), 1'b0, 1'b0, 2);
      end
      check("multi_hot", 64'(hot_err), 64'(0));

`ifdef ADDER_ARB_STATS_EN
      check("stat_ops",      64'(stat_ops),      64'(n_rsp));
      check("stat_timeouts", 64'(stat_timeouts), 64'(1));
      check("stat_wait_max", 64'(stat_wait_max), 64'(15));
`endif

      // Reset while in WAIT: operation dropped, requester 0 wins afterwards.
      request(3, 32'h5, 32'h6, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("mid_busy", 64'(busy), 64'(1));
      bus.req_a[0*WIDTH +: WIDTH] = 32'hA;
      bus.req_b[0*WIDTH +: WIDTH] = 32'h5;
      bus.req_cin[0]              = 1'b1;
      bus.req_valid               = '1;
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy",      64'(busy),          64'(0));
      check("mid_rst_adder_f",   64'(bus.adder_f),   64'(0));
      check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
      @(posedge clk);
      #1;
      reset_n     = 1'b1;
      model_delay = 1;
      @(negedge clk);
      check("post_rst_grant", 64'(bus.req_ready), 64'(4'b0001));
      @(posedge clk);
      #1;
      t_acc         = cyc;
      f_base        = f_cnt;
      bus.req_valid = '0;
      collect(0, 32'h0000_0010, 1'b0, 1'b0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
